// File: rtl/logic_unit_pkg.sv
// Shared definitions for the sequential logic unit: op codes, FSM states
// and a helper that flags the reserved op codes.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_ANDN = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Codes 110 and 111 have no operation behind them.
  function automatic logic is_reserved(input logic [2:0] op);
    return (op == 3'b110) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/logic_unit_seq_if.sv
// Request/result bundle between a sequencer (master) and the logic unit (slave).
//
// Handshake: the master raises start with op/a/b stable; the unit accepts it
// on any rising edge where it is not busy (IDLE or DONE). While busy=1 the
// start line is ignored and nothing is queued. done pulses for exactly one
// cycle when result/zero/parity/err become valid; those outputs then hold
// until the next accepted start.
interface logic_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             parity;
  logic             err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, parity, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, parity, err
  );
endinterface

// File: rtl/logic_slice.sv
// Combinational CHUNK-wide bitwise operation plus XOR reduction of its output.
// Reserved op codes produce an all-zero slice, so the assembled result is
// zero and contributes no parity.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [2:0]       op,
  output logic [CHUNK-1:0] y,
  output logic             red_xor
);

  // Select the operation for this chunk and fold its bits for parity.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      default: y = '0;
    endcase
    red_xor = ^y;
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: operands are latched on an accepted start,
// processed CHUNK bits per clock from the low end, and the assembled word is
// copied into a separate output register only when the last chunk finishes,
// so the visible result never shows partial shift contents.
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  logic_unit_seq_if.slave         bus,
  output state_t                  dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $fatal(1, "logic_unit_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             par_acc_q, par_acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic             err_q, err_d;

  logic [CHUNK-1:0] slice_y;
  logic             slice_red;
  logic [WIDTH-1:0] res_next;
  logic             accept;
  logic             busy;
  logic             done;

  logic_slice #(.CHUNK(CHUNK)) u_slice (
    .a       (a_sh_q[CHUNK-1:0]),
    .b       (b_sh_q[CHUNK-1:0]),
    .op      (op_q),
    .y       (slice_y),
    .red_xor (slice_red)
  );

  // Shift the finished chunk in at the top; after NCHUNK steps the first
  // chunk has reached bit 0. Written with shifts so CHUNK == WIDTH works.
  assign res_next = (res_sh_q >> CHUNK) | (WIDTH'(slice_y) << (WIDTH - CHUNK));

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_sh_d  = res_sh_q;
    par_acc_d = par_acc_q;
    result_d  = result_q;
    zero_d    = zero_q;
    parity_d  = parity_q;
    err_d     = err_q;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;

    case (state_q)
      S_IDLE: begin
        accept = bus.start;
      end
      S_RUN: begin
        busy      = 1'b1;
        a_sh_d    = a_sh_q >> CHUNK;
        b_sh_d    = b_sh_q >> CHUNK;
        res_sh_d  = res_next;
        par_acc_d = par_acc_q ^ slice_red;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = res_next;
          zero_d   = ~|res_next;
          parity_d = par_acc_q ^ slice_red;
          err_d    = is_reserved(op_q);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        accept  = bus.start;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An accepted start loads fresh operands; result and flags keep their
    // old values until the new operation completes.
    if (accept) begin
      state_d   = S_RUN;
      op_d      = bus.op;
      a_sh_d    = bus.a;
      b_sh_d    = bus.b;
      res_sh_d  = '0;
      cnt_d     = '0;
      par_acc_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_sh_q  <= '0;
      par_acc_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      parity_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_sh_q  <= res_sh_d;
      par_acc_q <= par_acc_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      parity_q  <= parity_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.parity = parity_q;
  assign bus.err    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/logic_unit_seq.md
Name: logic_unit_seq

Overview:
Parametrised multi-cycle bitwise logic unit. It generalises the fixed 32-bit XOR tree to selectable operations (AND/OR/XOR/NOR/XNOR/ANDN) on WIDTH-bit operands, processed CHUNK bits per clock. It adds a start/busy/done handshake and result flags (zero, parity, err). It sits beside the ALU as a low-area logical-op engine that the MIPS32 datapath control FSM sequences.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits processed per clock; CHUNK == WIDTH gives single-cycle processing.
NCHUNK, WIDTH/CHUNK (derived localparam), number of RUN cycles per operation.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high.
start  input  1  request; sampled only in IDLE or DONE.
op  input  3  operation code, latched with start.
a  input  WIDTH  operand A, latched with start.
b  input  WIDTH  operand B, latched with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when result is valid.
result  output  WIDTH  registered result; held until the next accepted start.
zero  output  1  result == 0; valid with done and held afterwards.
parity  output  1  XOR-reduction of result; valid with done and held afterwards.
err  output  1  reserved op code; valid with done and held afterwards.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high. Reset dominates all inputs.
- Reset values: state=IDLE, busy=0, done=0, result=0, zero=0, parity=0, err=0, chunk counter=0.
- Op codes: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 XNOR, 101 ANDN (a & ~b). Codes 110 and 111 are reserved: result=0, zero=1, parity=0, err=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b and op into internal shift registers, clears cnt and the parity accumulator, then enters RUN. start=0 stays in IDLE.
  - RUN: each edge applies op to the low CHUNK bits of the A/B shift registers. The chunk result enters the top of the result shift register (result shifts right by CHUNK). The chunk's XOR-reduction is folded into the parity accumulator. A/B shift right by CHUNK; cnt increments. When cnt == NCHUNK-1 at an edge, the state goes to DONE.
  - DONE: done=1 for exactly one cycle. result, zero, parity and err are valid. If start=1, the unit latches new operands and goes directly to RUN (back-to-back operation); otherwise it goes to IDLE.
- Latency: start sampled at edge E0 → chunk i is processed at edge E(i+1) → done is high in the cycle after edge E(NCHUNK). WIDTH=32, CHUNK=8 gives done 4 cycles after the start edge.
- busy=1 exactly in RUN. start in RUN is ignored and is not queued.
- During RUN the visible result is the old value. Exposing partial shift contents is forbidden: use a separate output register loaded at the RUN→DONE edge.
- zero and parity are computed from the final result and registered with it. After done falls, flags and result hold until the next accepted start.
- Reset mid-RUN: the next state is IDLE, all outputs return to reset values, and done never fires for the aborted operation.
- NCHUNK=1: one RUN cycle; done appears 1 cycle after the start edge.
- Elaboration check: WIDTH % CHUNK != 0 raises a fatal elaboration error.

Decomposition:
- Shared package logic_unit_pkg:
  - op-code localparams OP_AND, OP_OR, OP_XOR, OP_NOR, OP_XNOR, OP_ANDN;
  - FSM state encodings S_IDLE, S_RUN, S_DONE.
- Sub-module logic_slice: a purely combinational CHUNK-wide op and reduction. Inputs a, b, op; outputs y[CHUNK] and red_xor. It is instantiated once and reused each RUN cycle.
- The top module holds the FSM, counter, shift registers and flag registers.

Test Plan:
- Reset: assert reset 2 cycles with start=1 → busy=0, done=0, result=0, zero=0, parity=0, err=0; no RUN entry.
- XOR: op=010, a=0xFFFF0000, b=0x0F0F0F0F, start 1 cycle → busy high 4 cycles, done pulse on the 4th cycle after the start edge, result=0xF0F00F0F, zero=0, parity=0, err=0.
- AND/NOR/XNOR:
  - AND a=0x12345678, b=0 → result=0, zero=1.
  - NOR a=0, b=0 → 0xFFFFFFFF, parity=0.
  - XNOR a=0x00000001, b=0 → 0xFFFFFFFE, parity=1.
- Handshake:
  - start re-asserted during RUN → ignored; the result comes from the first operands.
  - start held high in the DONE cycle with ANDN a=0xFF, b=0x0F → new RUN begins immediately; next result=0x000000F0.
- Reset mid-op: XOR started, reset at the 2nd RUN edge → IDLE next cycle, result=0, no done pulse for that op.
- Reserved op 3'b111 with a=b=0xFFFFFFFF → done after 4 cycles, result=0, zero=1, err=1. Repeat with CHUNK=32 → done 1 cycle after the start edge.
